// File: rtl/rt_host_pkg.sv
// rtl/rt_host_pkg.sv - shared types and constants for the host SPI bridge
// Purpose: bridge FSM state encoding plus command-byte and register-map constants.
// Ports: none (package).
package rt_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RPREP,
    ST_RDATA
  } state_e;

  localparam int         CMD_RW_BIT  = 7;
  localparam int         REG_ADDR_W  = 6;
  localparam logic [5:0] STATUS_ADDR = 6'h30;

endpackage

// File: rtl/host_spi_bridge_if.sv
// rtl/host_spi_bridge_if.sv - host SPI pins and register-file strobe bus
// Purpose: groups the 4-wire SPI link and the register strobe protocol.
// Ports (signals):
//   sclk, cs_n, mosi        : SPI inputs from the host
//   miso, miso_oe           : SPI output and its enable
//   reg_addr, wr_data       : register address / write byte
//   wr_stb, rd_stb          : 1-cycle write / read-address strobes
//   rd_data                 : read byte returned by the register file
//   frame_err               : sticky partial-byte frame flag
// Modports: slave = bridge side, master = host/register-file side.
interface host_spi_bridge_if #(
  parameter int ADDR_W = 6
);

  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        wr_data;
  logic              wr_stb;
  logic              rd_stb;
  logic [7:0]        rd_data;
  logic              frame_err;

  modport slave (
    input  sclk, cs_n, mosi, rd_data,
    output miso, miso_oe, reg_addr, wr_data, wr_stb, rd_stb, frame_err
  );

  modport master (
    output sclk, cs_n, mosi, rd_data,
    input  miso, miso_oe, reg_addr, wr_data, wr_stb, rd_stb, frame_err
  );

endinterface

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - synchronizers and edge detection for the SPI inputs
// Purpose: brings sclk, cs_n and mosi into the clk domain and derives
//          1-cycle edge events.
// Ports:
//   clk, rst                : system clock, async active-high reset
//   sclk, cs_n, mosi        : raw asynchronous SPI inputs
//   sclk_rise, sclk_fall    : 1-cycle synchronized sclk edge events
//   cs_fall, cs_rise        : 1-cycle synchronized cs_n edge events
//   cs_active               : synchronized chip select asserted (cs_n low)
//   mosi_s                  : synchronized mosi, aligned with the sclk events
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_active,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_s, cs_s;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_active = ~cs_s;
  // mosi takes the same number of stages as sclk_s, so it is sampled at the
  // matching point of the bit cell when sclk_rise fires.
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/host_spi_bridge.sv
// rtl/host_spi_bridge.sv - SPI slave to register-file strobe bridge
// Purpose: decodes {rw, x, addr[5:0]} command frames from a mode-0 SPI host
//          into auto-incrementing register writes and prefetched reads.
// Ports:
//   clk, rst : system clock, async active-high reset
//   bus      : host_spi_bridge_if slave modport (SPI pins, strobes, rd_data,
//              frame_err)
module host_spi_bridge
  import rt_host_pkg::*;
#(
  parameter int ADDR_W      = REG_ADDR_W,
  parameter int RD_LAT      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  host_spi_bridge_if.slave       bus
);

  localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_active, mosi_s;
  logic sclk_rise_v, sclk_fall_v;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (bus.sclk),
    .cs_n      (bus.cs_n),
    .mosi      (bus.mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_active (cs_active),
    .mosi_s    (mosi_s)
  );

  assign sclk_rise_v = sclk_rise & cs_active;
  assign sclk_fall_v = sclk_fall & cs_active;

  state_e            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        rx_sh_q, rx_sh_d;
  logic [6:0]        tx_sh_q, tx_sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              wr_stb_q, wr_stb_d;
  logic              rd_stb_q, rd_stb_d;
  logic              frame_err_q, frame_err_d;
  logic              miso_q, miso_d;
  logic              rd_pend_q, rd_pend_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [7:0]        rx_byte;

  assign rx_byte = {rx_sh_q, mosi_s};

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    addr_d      = addr_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_stb_d    = 1'b0;
    rd_stb_d    = 1'b0;
    frame_err_d = frame_err_q;
    miso_d      = miso_q;
    rd_pend_d   = rd_pend_q;
    lat_cnt_d   = lat_cnt_q;

    if (cs_fall) begin
      // A fall also restarts a frame already in progress; any sclk rise in
      // this same cycle is deliberately not counted.
      state_d     = ST_CMD;
      bitcnt_d    = 3'd0;
      frame_err_d = 1'b0;
      miso_d      = 1'b0;
      rd_pend_d   = 1'b0;
    end else if (cs_rise) begin
      state_d   = ST_IDLE;
      bitcnt_d  = 3'd0;
      miso_d    = 1'b0;
      rd_pend_d = 1'b0;
      if (bitcnt_q != 3'd0) frame_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
        end
        ST_CMD: begin
          if (sclk_rise_v) begin
            rx_sh_d  = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              addr_d = rx_byte[ADDR_W-1:0];
              if (rx_byte[CMD_RW_BIT]) begin
                state_d   = ST_RPREP;
                rd_pend_d = 1'b1;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_WDATA: begin
          if (sclk_rise_v) begin
            rx_sh_d  = rx_byte[6:0];
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              wr_stb_d   = 1'b1;
              reg_addr_d = addr_q;
              wr_data_d  = rx_byte;
              addr_d     = addr_q + ADDR_W'(1);
            end
          end
        end
        ST_RPREP: begin
          // First cycle issues the strobe; the byte is taken RD_LAT cycles
          // after the strobe cycle and bit 7 goes straight onto miso.
          if (rd_pend_q) begin
            rd_stb_d   = 1'b1;
            reg_addr_d = addr_q;
            rd_pend_d  = 1'b0;
            lat_cnt_d  = LAT_W'(RD_LAT);
          end else if (lat_cnt_q == '0) begin
            tx_sh_d = bus.rd_data[6:0];
            miso_d  = bus.rd_data[7];
            state_d = ST_RDATA;
          end else begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
          end
        end
        ST_RDATA: begin
          if (sclk_rise_v) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              addr_d    = addr_q + ADDR_W'(1);
              state_d   = ST_RPREP;
              rd_pend_d = 1'b1;
            end
          end else if (sclk_fall_v && (bitcnt_q != 3'd0)) begin
            // The fall at a byte boundary is skipped: the prefetch already
            // placed bit 7 of the new byte on miso.
            miso_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[5:0], 1'b0};
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      wr_data_q   <= '0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      rd_pend_q   <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      addr_q      <= addr_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      rd_pend_q   <= rd_pend_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.miso_oe   = (state_q != ST_IDLE);
  assign bus.reg_addr  = reg_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_stb    = wr_stb_q;
  assign bus.rd_stb    = rd_stb_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_host_spi_bridge.sv
// tb/tb_host_spi_bridge.sv - self-checking bench for host_spi_bridge
module tb_host_spi_bridge;
  import rt_host_pkg::*;

  localparam int HALF = 100;

  logic clk;
  logic rst;

  host_spi_bridge_if #(.ADDR_W(6)) bus ();

  host_spi_bridge #(.ADDR_W(6), .RD_LAT(2), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ref_mem [0:63];
  logic [7:0] regfile [0:63];
  logic       mdl_load;
  logic [5:0] lat_addr;
  logic [7:0] rd_data_r;

  // Register-file model: data for the strobed address appears two cycles
  // after the rd_stb cycle.
  always @(posedge clk) begin
    if (mdl_load) begin
      for (int i = 0; i < 64; i++) regfile[i] <= ref_mem[i];
    end else if (bus.wr_stb) begin
      regfile[bus.reg_addr] <= bus.wr_data;
    end
    if (bus.rd_stb) lat_addr <= bus.reg_addr;
    rd_data_r <= regfile[lat_addr];
  end
  assign bus.rd_data = rd_data_r;

  logic [5:0] wr_a_log [$];
  logic [7:0] wr_d_log [$];
  logic [5:0] rd_a_log [$];
  int         both_cnt = 0;
  int         long_cnt = 0;
  logic       prev_wr = 1'b0;
  logic       prev_rd = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_stb) begin
      wr_a_log.push_back(bus.reg_addr);
      wr_d_log.push_back(bus.wr_data);
    end
    if (bus.rd_stb) rd_a_log.push_back(bus.reg_addr);
    if (bus.wr_stb && bus.rd_stb) both_cnt++;
    if ((bus.wr_stb && prev_wr) || (bus.rd_stb && prev_rd)) long_cnt++;
    prev_wr = bus.wr_stb;
    prev_rd = bus.rd_stb;
  end

  logic [7:0] tx_buf [0:7];
  logic [7:0] rx_buf [0:7];
  logic       err_at_start;
  logic       oe_in_frame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] v, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      bus.mosi = v[i];
      #(HALF);
      bus.sclk = 1'b1;
      r[i] = bus.miso;
      #(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int nbytes, input int tail_bits);
    logic [7:0] r;
    wr_a_log.delete();
    wr_d_log.delete();
    rd_a_log.delete();
    bus.cs_n = 1'b0;
    #(HALF);
    err_at_start = bus.frame_err;
    oe_in_frame  = bus.miso_oe;
    for (int b = 0; b < nbytes; b++) begin
      spi_bits(tx_buf[b], 8, r);
      rx_buf[b] = r;
    end
    if (tail_bits > 0) spi_bits(8'hC7, tail_bits, r);
    #(HALF);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    #(3 * HALF);
  endtask

  task automatic check_write(input string tag, input int n);
    logic [5:0] a;
    logic [5:0] ea;
    a = tx_buf[0][5:0];
    chk({tag, " wr count"}, wr_a_log.size(), n);
    chk({tag, " rd count"}, rd_a_log.size(), 0);
    for (int i = 0; i < n; i++) begin
      ea = 6'(a + 6'(i));
      if (i < wr_a_log.size()) begin
        chk({tag, " wr addr"}, wr_a_log[i], ea);
        chk({tag, " wr data"}, wr_d_log[i], tx_buf[i+1]);
      end
      ref_mem[ea] = tx_buf[i+1];
    end
    chk({tag, " miso_oe in frame"}, oe_in_frame, 1);
    chk({tag, " frame_err"}, bus.frame_err, 0);
    chk({tag, " miso_oe idle"}, bus.miso_oe, 0);
  endtask

  task automatic check_read(input string tag, input int n);
    logic [5:0] a;
    logic [5:0] ea;
    a = tx_buf[0][5:0];
    // One prefetch per data byte plus the one after the last byte.
    chk({tag, " rd count"}, rd_a_log.size(), n + 1);
    chk({tag, " wr count"}, wr_a_log.size(), 0);
    for (int i = 0; i <= n; i++) begin
      ea = 6'(a + 6'(i));
      if (i < rd_a_log.size()) chk({tag, " rd addr"}, rd_a_log[i], ea);
      if (i < n) chk({tag, " miso byte"}, rx_buf[i+1], ref_mem[ea]);
    end
    chk({tag, " frame_err"}, bus.frame_err, 0);
  endtask

  int         nb;
  logic       rw;
  logic [7:0] r8;

  initial begin
    rst      = 1'b1;
    mdl_load = 1'b1;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
    ref_mem[STATUS_ADDR] = 8'h15;
    ref_mem[6'h3F]       = 8'hA5;
    ref_mem[6'h00]       = 8'h5A;

    #22;
    chk("reset miso", bus.miso, 0);
    chk("reset miso_oe", bus.miso_oe, 0);
    chk("reset reg_addr", bus.reg_addr, 0);
    chk("reset wr_data", bus.wr_data, 0);
    chk("reset strobes", {bus.wr_stb, bus.rd_stb}, 0);
    chk("reset frame_err", bus.frame_err, 0);
    #10;
    rst      = 1'b0;
    mdl_load = 1'b0;
    #20;

    // Single write
    tx_buf[0] = 8'h10; tx_buf[1] = 8'h2A;
    spi_frame(2, 0);
    check_write("single wr", 1);

    // Burst write
    tx_buf[0] = 8'h14; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    tx_buf[3] = 8'h33; tx_buf[4] = 8'h44;
    spi_frame(5, 0);
    check_write("burst wr", 4);

    // Single read of the status address
    tx_buf[0] = {1'b1, 1'b0, STATUS_ADDR}; tx_buf[1] = 8'h00;
    spi_frame(2, 0);
    check_read("single rd", 1);
    chk("single rd value", rx_buf[1], 8'h15);

    // Burst read across the 0x3F -> 0x00 wrap
    tx_buf[0] = 8'hBF; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    spi_frame(3, 0);
    check_read("wrap rd", 2);
    chk("wrap rd byte0", rx_buf[1], 8'hA5);
    chk("wrap rd byte1", rx_buf[2], 8'h5A);

    // Aborted write after 5 data bits, then a clean write
    tx_buf[0] = 8'h05;
    spi_frame(1, 5);
    chk("abort wr count", wr_a_log.size(), 0);
    chk("abort frame_err", bus.frame_err, 1);
    tx_buf[0] = 8'h22; tx_buf[1] = 8'h9C;
    spi_frame(2, 0);
    chk("frame_err cleared at cs fall", err_at_start, 0);
    check_write("post-abort wr", 1);

    // Reset in the middle of a read data byte
    tx_buf[0] = 8'hB0;
    bus.cs_n = 1'b0;
    #(HALF);
    spi_bits(tx_buf[0], 8, r8);
    spi_bits(8'h00, 3, r8);
    chk("mid-read miso_oe", bus.miso_oe, 1);
    #4;
    rst = 1'b1;
    #1;
    chk("mid-read rst miso/oe", {bus.miso, bus.miso_oe}, 0);
    chk("mid-read rst strobes", {bus.wr_stb, bus.rd_stb, bus.frame_err}, 0);
    chk("mid-read rst reg_addr", bus.reg_addr, 0);
    chk("mid-read rst wr_data", bus.wr_data, 0);
    bus.cs_n = 1'b1;
    #25;
    rst = 1'b0;
    #(2 * HALF);
    tx_buf[0] = 8'h2E; tx_buf[1] = 8'h6B; tx_buf[2] = 8'hD4;
    spi_frame(3, 0);
    check_write("post-rst wr", 2);

    // Randomized frames against the reference register map
    for (int k = 0; k < 10; k++) begin
      nb = int'($urandom_range(1, 4));
      rw = 1'($urandom_range(0, 1));
      tx_buf[0] = {rw, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63))};
      for (int j = 1; j <= nb; j++) tx_buf[j] = 8'($urandom);
      spi_frame(nb + 1, 0);
      if (rw) check_read("rand rd", nb);
      else    check_write("rand wr", nb);
    end

    chk("no simultaneous strobes", both_cnt, 0);
    chk("strobe width", long_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
